// File: rtl/accel_pkg.sv
// Shared defaults and state encoding for the accelerator arithmetic blocks.
package accel_pkg;
  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem,
  input  logic [W:0]   dsr,
  input  logic         bit_in,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] shifted;

  // Partial remainder stays below |divisor| <= 2^(W-1), so W bits hold it.
  assign shifted  = {rem, bit_in};
  assign q_bit    = (shifted >= dsr);
  assign rem_next = q_bit ? W'(shifted - dsr) : shifted[W-1:0];
endmodule

// File: rtl/signed_divider.sv
// Multi-cycle truncating signed divider: sign/magnitude split, DIVIDEND_W
// restoring steps, sign fix-up, then result held until consumed.
module signed_divider import accel_pkg::*; #(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);
  localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  div_state_e state, state_nxt;

  logic [DIVIDEND_W-1:0] a_sh;   // dividend magnitude shifting out, quotient shifting in
  logic [DIVISOR_W:0]    b_mag;
  logic [DIVISOR_W-1:0]  rem;
  logic [CW-1:0]         cnt;
  logic                  neg_q, neg_r, dz_q, ovf_q;

  logic [DIVIDEND_W:0]   a_mag_in;
  logic [DIVISOR_W:0]    b_mag_in;
  logic                  dz_in, ovf_in;
  logic [DIVISOR_W-1:0]  rem_nxt;
  logic                  q_bit;

  // One extra bit so |most-negative| is exact.
  assign a_mag_in = dividend[DIVIDEND_W-1] ? -{dividend[DIVIDEND_W-1], dividend}
                                           :  {dividend[DIVIDEND_W-1], dividend};
  assign b_mag_in = divisor[DIVISOR_W-1]   ? -{divisor[DIVISOR_W-1], divisor}
                                           :  {divisor[DIVISOR_W-1], divisor};
  assign dz_in    = (divisor == '0);
  // |dividend| == 2^(DIVIDEND_W-1) only for the most-negative value.
  assign ovf_in   = (a_mag_in == {2'b01, {(DIVIDEND_W-1){1'b0}}}) &&
                    (b_mag_in == {{DIVISOR_W{1'b0}}, 1'b1}) && divisor[DIVISOR_W-1];

  div_step #(.W(DIVISOR_W)) u_step (
    .rem      (rem),
    .dsr      (b_mag),
    .bit_in   (a_sh[DIVIDEND_W-1]),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = dz_in ? DONE : ITER;
      ITER:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state == IDLE);
    out_valid   = (state == DONE);
    div_by_zero = out_valid & dz_q;
    overflow    = out_valid & ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_mag     <= '0;
      rem       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a_mag_in[DIVIDEND_W-1:0];
          b_mag <= b_mag_in;
          rem   <= '0;
          cnt   <= CW'(DIVIDEND_W - 1);
          neg_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          neg_r <= dividend[DIVIDEND_W-1];
          dz_q  <= dz_in;
          ovf_q <= ovf_in;
          if (dz_in) begin
            quotient  <= '0;
            remainder <= '0;
          end
        end
        ITER: begin
          a_sh <= {a_sh[DIVIDEND_W-2:0], q_bit};
          rem  <= rem_nxt;
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          quotient  <= neg_q ? -a_sh : a_sh;
          remainder <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_divider.sv
// Directed + random checks of signed_divider through a result scoreboard.
module tb_signed_divider;
  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, div_by_zero, overflow;
  logic [DW-1:0] dividend = '0, quotient;
  logic [VW-1:0] divisor = '0, remainder;

  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic          ovf;
    int            lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  signed_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er,
                        input logic edz, input logic eovf, input int elat,
                        input int hold, input bit pulse);
    exp_t e;
    int   lat;
    e.q = eq; e.r = er; e.dz = edz; e.ovf = eovf; e.lat = elat;
    sb.push_back(e);
    chk("in_ready_idle", in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk("busy_flags", {div_by_zero, overflow}, 0);
      if (pulse && lat == 5) begin in_valid = 1'b1; dividend = 16'h1234; divisor = 8'h03; end
      if (pulse && lat == 6) in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", div_by_zero, e.dz);
    chk("overflow", overflow, e.ovf);
    chk("in_ready_done", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_quotient", quotient, e.q);
      chk("hold_remainder", remainder, e.r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("flags_clear", {div_by_zero, overflow}, 0);
  endtask

  task automatic run_model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int ai, bi, qi, ri;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    ai = int'($signed(a));
    bi = int'($signed(b));
    qi = ai / bi;
    ri = ai % bi;
    eq = qi[DW-1:0];
    er = ri[VW-1:0];
    run_op(a, b, eq, er, 1'b0, (ai == -32768 && bi == -1), DW + 2, 0, 1'b0);
  endtask

  initial begin
    int seen;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b0, 18, 0, 1'b0);
    run_op(-16'sd1000, 8'd7, 16'hFF72, 8'hFA, 1'b0, 1'b0, 18, 0, 1'b0);
    run_op(16'd1000, -8'sd7, 16'hFF72, 8'd6, 1'b0, 1'b0, 18, 0, 1'b0);
    run_op(16'h8000, 8'hFF, 16'h8000, 8'd0, 1'b0, 1'b1, 18, 0, 1'b0);
    run_op(-16'sd16256, 8'h80, 16'd127, 8'd0, 1'b0, 1'b0, 18, 0, 1'b0);
    run_op(16'd5, 8'd0, 16'd0, 8'd0, 1'b1, 1'b0, 1, 0, 1'b0);
    run_op(-16'sd7, 8'd2, 16'hFFFD, 8'hFF, 1'b0, 1'b0, 18, 5, 1'b1);

    // Abandon an operation mid-iteration.
    dividend = 16'd300; divisor = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_result_after_reset", seen, 0);
    run_op(16'd300, 8'd9, 16'd33, 8'd3, 1'b0, 1'b0, 18, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      run_model(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 16, dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 8, divisor and remainder width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block idle, can accept operands.
REQ-007 SHALL have port dividend  input  DIVIDEND_W  signed two's-complement dividend.
REQ-008 SHALL have port divisor  input  DIVISOR_W  signed two's-complement divisor.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quotient  output  DIVIDEND_W  signed quotient.
REQ-012 SHALL have port remainder  output  DIVISOR_W  signed remainder.
REQ-013 SHALL have port div_by_zero  output  1  divisor was zero.
REQ-014 SHALL have port overflow  output  1  quotient not representable.

Function
REQ-015 SHALL compute truncating signed division: quotient rounded toward zero, remainder sign equals dividend sign, dividend = quotient*divisor + remainder.
REQ-016 SHALL use FSM states IDLE, ITER, FIX, DONE.
REQ-017 SHALL assert in_ready only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-018 On acceptance with divisor != 0: latch operand magnitudes and signs, clear partial remainder, load iteration counter DIVIDEND_W-1, go to ITER.
REQ-019 ITER SHALL perform one radix-2 restoring step per cycle (shift in next dividend magnitude MSB, trial-subtract divisor magnitude, keep if non-negative, set quotient bit), exactly DIVIDEND_W cycles, then go to FIX.
REQ-020 FIX SHALL negate quotient if operand signs differ and negate remainder if dividend negative, then go to DONE.
REQ-021 out_valid SHALL rise DIVIDEND_W+2 rising edges after the acceptance edge (18 for defaults).
REQ-022 On acceptance with divisor == 0: go directly to DONE, quotient=0, remainder=0, div_by_zero=1; out_valid one edge after acceptance.
REQ-023 Dividend = most-negative value with divisor = -1 SHALL complete normally, quotient = most-negative value (wrapped), remainder=0, overflow=1.
REQ-024 Internal magnitudes SHALL be one bit wider than operands so |most-negative| is exact.
REQ-025 DONE SHALL hold out_valid and all result outputs stable until out_ready is high at a rising edge, then return to IDLE.
REQ-026 in_valid while not in IDLE SHALL be ignored; no operand capture.
REQ-027 div_by_zero and overflow SHALL be meaningful only while out_valid, and 0 otherwise.

Reset
REQ-028 rst_n low SHALL immediately force IDLE: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter and datapath cleared.
REQ-029 Reset asserted mid-ITER/FIX/DONE SHALL abandon the operation with no result emitted after release.

Structure
REQ-030 Shared package accel_pkg SHALL hold DIVIDEND_W/DIVISOR_W defaults and the divider state enum.
REQ-031 One sub-module div_step SHALL implement the combinational single restoring step (partial remainder, divisor magnitude, incoming bit -> next remainder, quotient bit).

Verification
REQ-032 1000 / 7 -> quotient=142, remainder=6, flags 0, out_valid 18 edges after accept.
REQ-033 -1000 / 7 -> quotient=-142 (0xFF72), remainder=-6 (0xFA); 1000 / -7 -> quotient=-142, remainder=6.
REQ-034 -32768 / -1 -> quotient=0x8000, remainder=0, overflow=1; -16256 / -128 -> quotient=127, remainder=0, overflow=0.
REQ-035 5 / 0 -> div_by_zero=1, quotient=0, remainder=0, out_valid one edge after accept.
REQ-036 out_ready held low 5 cycles in DONE -> outputs stable; in_valid pulsed during ITER -> ignored; operands changing after the acceptance edge -> result unaffected.
REQ-037 rst_n pulsed low mid-ITER -> out_valid=0, in_ready=1 immediately; next operation after release correct.
